// File: rtl/kbd_pkg.sv
// ============================================================================
// kbd_pkg
// Shared prefix bytes and FSM state encoding for the PS/2 keyboard controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package kbd_pkg;

  localparam logic [7:0] KB_BREAK = 8'hF0;
  localparam logic [7:0] KB_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_PROC = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/kbd_if.sv
// ============================================================================
// kbd_if
// Handshake between the PS/2 receiver FIFO (slave) and its controller (master).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface kbd_if;

  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_nextdata_n;

  modport master (
    input  kb_data,
    input  kb_ready,
    input  kb_overflow,
    output kb_nextdata_n
  );

  modport slave (
    output kb_data,
    output kb_ready,
    output kb_overflow,
    input  kb_nextdata_n
  );

endinterface

`default_nettype wire

// File: rtl/scancode_ascii.sv
// ============================================================================
// scancode_ascii
// Combinational scan-code-set-2 to ASCII lookup; extended keys map to 0x00.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scancode_ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: ascii = 8'h61;
        8'h32: ascii = 8'h62;
        8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64;
        8'h24: ascii = 8'h65;
        8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67;
        8'h33: ascii = 8'h68;
        8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A;
        8'h42: ascii = 8'h6B;
        8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D;
        8'h31: ascii = 8'h6E;
        8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70;
        8'h15: ascii = 8'h71;
        8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73;
        8'h2C: ascii = 8'h74;
        8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76;
        8'h1D: ascii = 8'h77;
        8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79;
        8'h1A: ascii = 8'h7A;
        // top-row digits in set 2 are not contiguous
        8'h16: ascii = 8'h31;
        8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33;
        8'h25: ascii = 8'h34;
        8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36;
        8'h3D: ascii = 8'h37;
        8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h45: ascii = 8'h30;
        8'h29: ascii = 8'h20;
        8'h5A: ascii = 8'h0D;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/kbd_ctrl.sv
// ============================================================================
// kbd_ctrl
// Pops the PS/2 FIFO, parses make/break/extended prefixes, tracks the held key.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int COUNT_MAX = 99,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  kbd_if.master            kb,
  output logic [7:0]       cur_scancode,
  output logic             cur_ext,
  output logic [7:0]       cur_ascii,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_flag
);

  state_t           r_state;
  logic             r_nextdata_n;
  logic [7:0]       r_byte;
  logic             r_brk_pend;
  logic             r_ext_pend;
  logic [7:0]       r_scancode;
  logic             r_cur_ext;
  logic             r_key_valid;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  state_t           w_state_nxt;
  logic             w_nextdata_n_nxt;
  logic [7:0]       w_byte_nxt;
  logic             w_brk_nxt;
  logic             w_extp_nxt;
  logic [7:0]       w_scancode_nxt;
  logic             w_cur_ext_nxt;
  logic             w_key_valid_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_same_key;
  logic [CNT_W-1:0] w_count_inc;

  // Same physical key as the one held, including its extended-ness.
  assign w_same_key  = r_key_valid && (r_byte == r_scancode) && (r_ext_pend == r_cur_ext);
  assign w_count_inc = (r_count == CNT_W'(COUNT_MAX)) ? '0 : r_count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_nextdata_n <= 1'b1;
      r_byte       <= 8'h00;
      r_brk_pend   <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_scancode   <= 8'h00;
      r_cur_ext    <= 1'b0;
      r_key_valid  <= 1'b0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_nextdata_n <= w_nextdata_n_nxt;
      r_byte       <= w_byte_nxt;
      r_brk_pend   <= w_brk_nxt;
      r_ext_pend   <= w_extp_nxt;
      r_scancode   <= w_scancode_nxt;
      r_cur_ext    <= w_cur_ext_nxt;
      r_key_valid  <= w_key_valid_nxt;
      r_count      <= w_count_nxt;
      r_ovf        <= r_ovf | kb.kb_overflow;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_nextdata_n_nxt = 1'b1;
    w_byte_nxt       = r_byte;
    w_brk_nxt        = r_brk_pend;
    w_extp_nxt       = r_ext_pend;
    w_scancode_nxt   = r_scancode;
    w_cur_ext_nxt    = r_cur_ext;
    w_key_valid_nxt  = r_key_valid;
    w_count_nxt      = r_count;

    case (r_state)
      S_IDLE: begin
        if (kb.kb_ready) begin
          w_byte_nxt       = kb.kb_data;
          w_nextdata_n_nxt = 1'b0;
          w_state_nxt      = S_ACK;
        end
      end

      // FIFO read pointer is still moving; kb_ready is not trusted here.
      S_ACK: begin
        w_state_nxt = S_PROC;
      end

      S_PROC: begin
        w_state_nxt = S_IDLE;
        if (r_byte == KB_EXT) begin
          w_extp_nxt = 1'b1;
        end else if (r_byte == KB_BREAK) begin
          w_brk_nxt = 1'b1;
        end else if (r_brk_pend) begin
          if (w_same_key) begin
            w_key_valid_nxt = 1'b0;
          end
          w_brk_nxt  = 1'b0;
          w_extp_nxt = 1'b0;
        end else begin
          // Typematic repeats of the held key neither update nor count.
          if (!w_same_key) begin
            w_scancode_nxt  = r_byte;
            w_cur_ext_nxt   = r_ext_pend;
            w_key_valid_nxt = 1'b1;
            w_count_nxt     = w_count_inc;
          end
          w_extp_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  scancode_ascii u_ascii (
    .code  (r_scancode),
    .ext   (r_cur_ext),
    .ascii (cur_ascii)
  );

  assign kb.kb_nextdata_n = r_nextdata_n;
  assign cur_scancode     = r_scancode;
  assign cur_ext          = r_cur_ext;
  assign key_valid        = r_key_valid;
  assign press_count      = r_count;
  assign ovf_flag         = r_ovf;

endmodule

`default_nettype wire
